aes_round_key_buffer: RTL and testbench

- Consumer side of the round-counter interface driven by the AES sequencing FSM.
- Accepts expanded 128-bit round keys from the key-expansion unit over a valid/ready handshake and stores them.
- Serves the round key for the current round index: forward order for encryption, reverse order for decryption.
- Lets the sequencer run encrypt and decrypt passes off one stored schedule for AES-128/192/256.

---
 rtl/aes_round_key_buffer.sv | 131 +++++++++++++
 tb/tb_aes_round_key_buffer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_key_buffer.sv
// Round-key store for the AES datapath: fills k0..kNr over valid/ready and
// serves the key for the requested round, forward for encrypt, reversed for decrypt.
module aes_round_key_buffer #(
    parameter int KEY_W    = 128,
    parameter int MAX_KEYS = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [3:0]       round,
    input  logic             enc_dec,
    output logic [KEY_W-1:0] round_key,
    output logic             keys_ready,
    output logic             mode_err,
    output logic             range_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_FULL
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [1:0]       mode_reg_q, mode_reg_d;
    logic             mode_err_q, mode_err_d;
    logic             range_err_q, range_err_d;
    logic [KEY_W-1:0] round_key_q, round_key_d;
    logic [KEY_W-1:0] mem_q [MAX_KEYS];

    logic       wr_en;
    logic       load_ok;
    logic       load_bad;
    logic [3:0] nr;
    logic [3:0] idx;

    assign load_ok  = load && (mode != 2'b11);
    assign load_bad = load && (mode == 2'b11);

    // Nr follows the latched key size so a live mode change cannot disturb reads
    always_comb begin
        case (mode_reg_q)
            2'b01:   nr = 4'd12;
            2'b10:   nr = 4'd14;
            default: nr = 4'd10;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mode_reg_d = mode_reg_q;
        mode_err_d = mode_err_q;
        wr_en      = 1'b0;
        if (load_bad) begin
            state_d    = S_IDLE;
            mode_err_d = 1'b1;
        end else if (load_ok) begin
            state_d    = S_FILL;
            count_d    = 4'd0;
            mode_reg_d = mode;
            mode_err_d = 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (key_valid) begin
                        wr_en = 1'b1;
                        if (count_q == nr) begin
                            state_d = S_FULL;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign key_ready  = (state_q == S_FILL);
    assign keys_ready = (state_q == S_FULL);

    // Nr - round is only formed once round <= Nr, so idx never wraps
    always_comb begin
        round_key_d = '0;
        range_err_d = 1'b0;
        idx         = round;
        if (keys_ready) begin
            if (round <= nr) begin
                idx         = enc_dec ? (nr - round) : round;
                round_key_d = mem_q[idx];
            end else begin
                range_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q] <= key_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= 4'd0;
            mode_reg_q  <= 2'b00;
            mode_err_q  <= 1'b0;
            range_err_q <= 1'b0;
            round_key_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mode_reg_q  <= mode_reg_d;
            mode_err_q  <= mode_err_d;
            range_err_q <= range_err_d;
            round_key_q <= round_key_d;
        end
    end

    assign round_key = round_key_q;
    assign mode_err  = mode_err_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_aes_round_key_buffer.sv
// Scoreboard bench for aes_round_key_buffer: driver queues expected values
// tagged with the cycle they are due; a negedge monitor compares them.
module tb_aes_round_key_buffer;

   logic         clk;
   logic         reset;
   logic [1:0]   mode;
   logic         load;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic [3:0]   round;
   logic         enc_dec;
   logic [127:0] round_key;
   logic         keys_ready;
   logic         mode_err;
   logic         range_err;

   aes_round_key_buffer #(.KEY_W(128), .MAX_KEYS(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .load      (load),
      .key_in    (key_in),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .round     (round),
      .enc_dec   (enc_dec),
      .round_key (round_key),
      .keys_ready(keys_ready),
      .mode_err  (mode_err),
      .range_err (range_err)
   );

   typedef struct {
      int           cyc;
      int           sig;
      logic [127:0] val;
   } exp_t;

   exp_t         sb[$];
   int           cyc     = 0;
   int           n_cmp   = 0;
   int           n_mis   = 0;
   int           acc_cnt = 0;
   int           exp_acc = 0;
   logic [127:0] act;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   function automatic string sig_name(input int s);
      case (s)
         0:       return "round_key";
         1:       return "range_err";
         2:       return "keys_ready";
         3:       return "key_ready";
         4:       return "mode_err";
         default: return "accepted";
      endcase
   endfunction

   function automatic logic [127:0] kv(input int base, input int i);
      return {4{32'(base + i)}};
   endfunction

   // Monitor: compare everything due this cycle, then count the handshake
   // that the coming edge will complete.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            case (sb[i].sig)
               0:       act = round_key;
               1:       act = {127'b0, range_err};
               2:       act = {127'b0, keys_ready};
               3:       act = {127'b0, key_ready};
               4:       act = {127'b0, mode_err};
               default: act = 128'(acc_cnt);
            endcase
            n_cmp++;
            if (act !== sb[i].val) begin
               n_mis++;
               $display("FAIL %s cyc=%0d got=%h want=%h", sig_name(sb[i].sig), cyc, act, sb[i].val);
            end
            sb.delete(i);
         end
      end
      if (key_valid && key_ready && !load) acc_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int c, input int sig, input logic [127:0] v);
      exp_t e;
      e.cyc = c;
      e.sig = sig;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic expect_idle_outputs();
      expect_at(cyc, 0, 128'd0);
      expect_at(cyc, 1, 128'd0);
      expect_at(cyc, 2, 128'd0);
      expect_at(cyc, 3, 128'd0);
      expect_at(cyc, 4, 128'd0);
   endtask

   task automatic do_load(input logic [1:0] m);
      load = 1'b1;
      mode = m;
      tick();
      load = 1'b0;
   endtask

   task automatic fill(input int base, input int n, input bit gap);
      for (int i = 0; i < n; i++) begin
         key_in    = kv(base, i);
         key_valid = 1'b1;
         if (i == n - 1) begin
            expect_at(cyc, 2, 128'd0);
            expect_at(cyc, 3, 128'd1);
         end
         tick();
         exp_acc++;
         if (i == n - 1) begin
            expect_at(cyc, 2, 128'd1);
            expect_at(cyc, 3, 128'd0);
            expect_at(cyc, 5, 128'(exp_acc));
         end
         key_valid = 1'b0;
         if (gap) tick();
      end
   endtask

   task automatic rd(input logic ed, input logic [3:0] r, input logic [127:0] ek, input logic er);
      enc_dec = ed;
      round   = r;
      expect_at(cyc + 1, 0, ek);
      expect_at(cyc + 1, 1, {127'b0, er});
      tick();
   endtask

   initial begin
      reset     = 1'b1;
      load      = 1'b0;
      mode      = 2'b00;
      key_in    = '0;
      key_valid = 1'b0;
      round     = 4'd0;
      enc_dec   = 1'b0;
      tick();
      tick();
      expect_idle_outputs();
      reset = 1'b0;
      tick();

      // AES-128 fill, forward read
      do_load(2'b00);
      fill(0, 11, 1'b0);
      n_cmp++;
      if (keys_ready !== 1'b1) begin
         n_mis++;
         $display("FAIL direct keys_ready after AES-128 fill got=%b", keys_ready);
      end
      n_cmp++;
      if (key_ready !== 1'b0) begin
         n_mis++;
         $display("FAIL direct key_ready after AES-128 fill got=%b", key_ready);
      end
      rd(1'b0, 4'd3, kv(0, 3), 1'b0);

      // reverse sweep plus one past Nr
      for (int r = 0; r <= 11; r++) begin
         rd(1'b1, 4'(r), (r <= 10) ? kv(0, 10 - r) : 128'd0, (r > 10));
      end

      // AES-256 gapped fill; live mode change must not alter Nr
      do_load(2'b10);
      fill(256, 15, 1'b1);
      rd(1'b1, 4'd14, kv(256, 0), 1'b0);
      rd(1'b0, 4'd14, kv(256, 14), 1'b0);
      mode = 2'b00;
      rd(1'b1, 4'd12, kv(256, 2), 1'b0);
      rd(1'b0, 4'd15, 128'd0, 1'b1);
      key_in    = kv(32'h999, 0);
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
      expect_at(cyc, 5, 128'(exp_acc));
      rd(1'b0, 4'd0, kv(256, 0), 1'b0);

      // AES-192 partial fill aborted by a fresh load with a colliding valid
      do_load(2'b01);
      for (int i = 0; i < 5; i++) begin
         key_in    = kv(32'h200, i);
         key_valid = 1'b1;
         tick();
         exp_acc++;
      end
      load      = 1'b1;
      mode      = 2'b00;
      key_in    = kv(32'h2FF, 0);
      key_valid = 1'b1;
      tick();
      load      = 1'b0;
      key_valid = 1'b0;
      expect_at(cyc, 5, 128'(exp_acc));
      fill(32'h300, 11, 1'b0);
      rd(1'b0, 4'd0, kv(32'h300, 0), 1'b0);
      rd(1'b1, 4'd0, kv(32'h300, 10), 1'b0);

      // reserved mode from FULL
      load    = 1'b1;
      mode    = 2'b11;
      enc_dec = 1'b0;
      round   = 4'd2;
      tick();
      load = 1'b0;
      n_cmp++;
      if (mode_err !== 1'b1) begin
         n_mis++;
         $display("FAIL direct mode_err after reserved load got=%b", mode_err);
      end
      expect_at(cyc, 4, 128'd1);
      expect_at(cyc, 2, 128'd0);
      expect_at(cyc, 3, 128'd0);
      tick();
      expect_at(cyc, 0, 128'd0);
      expect_at(cyc, 1, 128'd0);
      do_load(2'b00);
      expect_at(cyc, 4, 128'd0);
      expect_at(cyc, 3, 128'd1);

      // async reset mid-fill, asserted between edges
      for (int i = 0; i < 7; i++) begin
         key_in    = kv(32'h400, i);
         key_valid = 1'b1;
         tick();
         exp_acc++;
      end
      key_valid = 1'b0;
      expect_at(cyc, 3, 128'd1);
      tick();
      reset = 1'b1;
      #1;
      n_cmp++;
      if (key_ready !== 1'b0) begin
         n_mis++;
         $display("FAIL direct async reset key_ready got=%b", key_ready);
      end
      n_cmp++;
      if (keys_ready !== 1'b0) begin
         n_mis++;
         $display("FAIL direct async reset keys_ready got=%b", keys_ready);
      end
      n_cmp++;
      if (round_key !== 128'd0) begin
         n_mis++;
         $display("FAIL direct async reset round_key got=%h", round_key);
      end
      n_cmp++;
      if (mode_err !== 1'b0) begin
         n_mis++;
         $display("FAIL direct async reset mode_err got=%b", mode_err);
      end
      expect_idle_outputs();
      tick();
      tick();
      reset = 1'b0;
      tick();
      key_in    = kv(32'h500, 0);
      key_valid = 1'b1;
      tick();
      tick();
      key_valid = 1'b0;
      expect_at(cyc, 5, 128'(exp_acc));
      expect_at(cyc, 3, 128'd0);
      expect_at(cyc, 2, 128'd0);

      for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
      while (sb.size() > 0) begin
         n_cmp++;
         n_mis++;
         $display("FAIL timeout %s due_cyc=%0d got=none want=%h", sig_name(sb[0].sig), sb[0].cyc, sb[0].val);
         void'(sb.pop_front());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
